// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller: jump flush, load-use and busy holds, trap sequencing FSM.
// Optional bus-stall watchdog enabled by defining PIPE_CTRL_STALL_TIMEOUT_EN.
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_jump_req_i,
    input  logic [31:0] ex_jump_addr_i,
    input  logic        load_use_i,
    input  logic        div_busy_i,
    input  logic        bus_busy_i,
    input  logic        trap_req_i,
    input  logic [31:0] trap_addr_i,
    output logic [2:0]  hold_flag_o,
    output logic        pip_flush_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic        trap_ack_o,
    output logic        stall_timeout_o
);

    localparam logic [2:0] HOLD_NONE   = 3'b000;
    localparam logic [2:0] HOLD_ID     = 3'b010;
    localparam logic [2:0] HOLD_ID_EX  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_DRAIN    = 2'b01,
        ST_REDIRECT = 2'b10
    } trap_state_e;

    trap_state_e state_r;
    logic [31:0] trap_addr_r;
    logic        lu_block_r;
    logic        lu_hold_s;
    logic        stall_flag_s;

    logic [2:0]  hold_s;
    logic        flush_s;
    logic        jump_s;
    logic [31:0] addr_s;
    logic        ack_s;

    // Load-use hold is the lowest-priority request and fires once per hazard.
    always_comb begin
        lu_hold_s = 1'b0;
        if ((state_r == ST_IDLE) && load_use_i && !lu_block_r && !trap_req_i &&
            !ex_jump_req_i && !bus_busy_i && !div_busy_i) begin
            lu_hold_s = 1'b1;
        end else begin
            lu_hold_s = 1'b0;
        end
    end

    // Trap sequencing FSM, trap vector capture and load-use block bit.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_r     <= ST_IDLE;
            trap_addr_r <= 32'h0000_0000;
            lu_block_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (trap_req_i) begin
                        trap_addr_r <= trap_addr_i;
                        state_r     <= bus_busy_i ? ST_DRAIN : ST_REDIRECT;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (!bus_busy_i) begin
                        state_r <= ST_REDIRECT;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_REDIRECT: state_r <= ST_IDLE;
                default:     state_r <= ST_IDLE;
            endcase
            // Block stays armed only while the same hazard persists.
            lu_block_r <= load_use_i & (lu_block_r | lu_hold_s);
        end
    end

    // Output resolution: FSM state first, then fixed request priority in IDLE.
    always_comb begin
        hold_s  = HOLD_NONE;
        flush_s = 1'b0;
        jump_s  = 1'b0;
        addr_s  = 32'h0000_0000;
        ack_s   = 1'b0;
        if (rst_n) begin
            hold_s = HOLD_NONE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (trap_req_i) begin
                        hold_s = HOLD_NONE;
                    end else if (ex_jump_req_i) begin
                        flush_s = 1'b1;
                        jump_s  = 1'b1;
                        addr_s  = ex_jump_addr_i;
                    end else if (bus_busy_i || div_busy_i) begin
                        hold_s = HOLD_ID_EX;
                    end else if (lu_hold_s) begin
                        hold_s = HOLD_ID;
                    end else begin
                        hold_s = HOLD_NONE;
                    end
                end
                ST_DRAIN: begin
                    hold_s = HOLD_ID_EX;
                end
                ST_REDIRECT: begin
                    flush_s = 1'b1;
                    jump_s  = 1'b1;
                    addr_s  = trap_addr_r;
                    ack_s   = 1'b1;
                end
                default: begin
                    hold_s = HOLD_NONE;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_STALL_TIMEOUT_EN
    logic [7:0] stall_cnt_r;
    logic       stall_timeout_r;

    // Consecutive bus-busy counter; flag latches when the count saturates.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            stall_cnt_r     <= 8'd0;
            stall_timeout_r <= 1'b0;
        end else begin
            if (!bus_busy_i) begin
                stall_cnt_r <= 8'd0;
            end else if (stall_cnt_r != 8'hFF) begin
                stall_cnt_r <= stall_cnt_r + 8'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (bus_busy_i && (stall_cnt_r == 8'hFE)) begin
                stall_timeout_r <= 1'b1;
            end else begin
                stall_timeout_r <= stall_timeout_r;
            end
        end
    end

    assign stall_flag_s = stall_timeout_r;
`else
    assign stall_flag_s = 1'b0;
`endif

    assign hold_flag_o     = hold_s;
    assign pip_flush_o     = flush_s;
    assign jump_flag_o     = jump_s;
    assign jump_addr_o     = addr_s;
    assign trap_ack_o      = ack_s;
    assign stall_timeout_o = stall_flag_s & ~rst_n;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; watchdog expectation follows PIPE_CTRL_STALL_TIMEOUT_EN.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ex_jump_req_i;
    logic [31:0] ex_jump_addr_i;
    logic        load_use_i;
    logic        div_busy_i;
    logic        bus_busy_i;
    logic        trap_req_i;
    logic [31:0] trap_addr_i;
    logic [2:0]  hold_flag_o;
    logic        pip_flush_o;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic        trap_ack_o;
    logic        stall_timeout_o;

    int checks = 0;
    int errors = 0;

`ifdef PIPE_CTRL_STALL_TIMEOUT_EN
    localparam logic TO_EXP = 1'b1;
`else
    localparam logic TO_EXP = 1'b0;
`endif

    pipe_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex_jump_req_i   (ex_jump_req_i),
        .ex_jump_addr_i  (ex_jump_addr_i),
        .load_use_i      (load_use_i),
        .div_busy_i      (div_busy_i),
        .bus_busy_i      (bus_busy_i),
        .trap_req_i      (trap_req_i),
        .trap_addr_i     (trap_addr_i),
        .hold_flag_o     (hold_flag_o),
        .pip_flush_o     (pip_flush_o),
        .jump_flag_o     (jump_flag_o),
        .jump_addr_o     (jump_addr_o),
        .trap_ack_o      (trap_ack_o),
        .stall_timeout_o (stall_timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout obs=running exp=finished");
        $fatal(1, "time limit");
    end

    function automatic logic [37:0] ov(input logic [2:0] h, input logic f, input logic j,
                                       input logic [31:0] a, input logic k);
        return {h, f, j, a, k};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [37:0] exp);
        logic [37:0] obs;
        #1;
        obs = {hold_flag_o, pip_flush_o, jump_flag_o, jump_addr_o, trap_ack_o};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_to(input string tag, input logic exp);
        #1;
        checks++;
        assert (stall_timeout_o === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, stall_timeout_o, exp);
        end
    endtask

    localparam logic [37:0] ZERO = 38'd0;

    initial begin
        // Reset with every request active: outputs must stay quiet.
        rst_n = 1'b1; ex_jump_req_i = 1'b1; ex_jump_addr_i = 32'h1234_5678;
        load_use_i = 1'b1; div_busy_i = 1'b1; bus_busy_i = 1'b1;
        trap_req_i = 1'b1; trap_addr_i = 32'hDEAD_BEEF;
        chk("reset_outputs", ZERO);
        chk_to("reset_timeout", 1'b0);
        tick(); tick();
        rst_n = 1'b0; ex_jump_req_i = 1'b0; ex_jump_addr_i = 32'h0; load_use_i = 1'b0;
        div_busy_i = 1'b0; bus_busy_i = 1'b0; trap_req_i = 1'b0; trap_addr_i = 32'h0;
        chk("idle_after_reset", ZERO);

        // Zero-latency jump.
        ex_jump_req_i = 1'b1; ex_jump_addr_i = 32'h8000_0040;
        chk("jump", ov(3'b000, 1'b1, 1'b1, 32'h8000_0040, 1'b0));
        tick();
        ex_jump_req_i = 1'b0;
        chk("jump_released", ZERO);

        // Load-use held 3 cycles: one hold only, re-armed after it drops.
        load_use_i = 1'b1;
        chk("lu_cycle1", ov(3'b010, 1'b0, 1'b0, 32'h0, 1'b0));
        tick();
        chk("lu_cycle2", ZERO);
        tick();
        chk("lu_cycle3", ZERO);
        tick();
        load_use_i = 1'b0;
        chk("lu_dropped", ZERO);
        tick();
        load_use_i = 1'b1;
        chk("lu_rearmed", ov(3'b010, 1'b0, 1'b0, 32'h0, 1'b0));
        tick();
        load_use_i = 1'b0;

        // Priority among busy, jump and load-use.
        div_busy_i = 1'b1;
        chk("div_busy", ov(3'b011, 1'b0, 1'b0, 32'h0, 1'b0));
        tick();
        div_busy_i = 1'b0; bus_busy_i = 1'b1; load_use_i = 1'b1;
        chk("bus_over_lu", ov(3'b011, 1'b0, 1'b0, 32'h0, 1'b0));
        tick();
        bus_busy_i = 1'b0; ex_jump_req_i = 1'b1; ex_jump_addr_i = 32'h0000_2000;
        chk("jump_over_lu", ov(3'b000, 1'b1, 1'b1, 32'h0000_2000, 1'b0));
        tick();
        ex_jump_req_i = 1'b0; load_use_i = 1'b0; ex_jump_addr_i = 32'h0;
        tick();

        // Trap while bus busy for 4 cycles: drain then one redirect cycle.
        trap_req_i = 1'b1; trap_addr_i = 32'h8000_0100; bus_busy_i = 1'b1;
        chk("trap_accept", ZERO);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("trap_drain", ov(3'b011, 1'b0, 1'b0, 32'h0, 1'b0));
            tick();
        end
        bus_busy_i = 1'b0;
        chk("trap_drain_last", ov(3'b011, 1'b0, 1'b0, 32'h0, 1'b0));
        tick();
        chk("trap_redirect", ov(3'b000, 1'b1, 1'b1, 32'h8000_0100, 1'b1));
        trap_req_i = 1'b0;
        tick();
        chk("trap_done", ZERO);

        // Trap and jump together, bus idle: trap target wins next cycle.
        trap_req_i = 1'b1; trap_addr_i = 32'h8000_0200;
        ex_jump_req_i = 1'b1; ex_jump_addr_i = 32'h8000_0040;
        chk("trap_jump_same", ZERO);
        tick();
        chk("trap_jump_redirect", ov(3'b000, 1'b1, 1'b1, 32'h8000_0200, 1'b1));
        trap_req_i = 1'b0; ex_jump_req_i = 1'b0; ex_jump_addr_i = 32'h0;
        tick();
        chk("trap_jump_done", ZERO);

        // Reset during DRAIN aborts the trap.
        trap_req_i = 1'b1; trap_addr_i = 32'h8000_0300; bus_busy_i = 1'b1;
        tick();
        chk("abort_in_drain", ov(3'b011, 1'b0, 1'b0, 32'h0, 1'b0));
        rst_n = 1'b1;
        chk("abort_during_reset", ZERO);
        tick();
        rst_n = 1'b0; trap_req_i = 1'b0; bus_busy_i = 1'b0;
        chk("abort_idle", ZERO);
        tick();
        chk("abort_no_ack", ZERO);

        // Bus stall watchdog over 300 busy cycles.
        bus_busy_i = 1'b1;
        for (int i = 0; i < 254; i++) tick();
        chk_to("wd_254", 1'b0);
        tick();
        chk_to("wd_255", TO_EXP);
        for (int i = 0; i < 45; i++) tick();
        chk("wd_hold", ov(3'b011, 1'b0, 1'b0, 32'h0, 1'b0));
        bus_busy_i = 1'b0;
        tick();
        chk_to("wd_sticky", TO_EXP);
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        chk_to("wd_cleared", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL provide the following ports, clock and reset first:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous, active-high reset; port name per codebase convention
- ex_jump_req_i  in  1  EX resolved taken branch/jump
- ex_jump_addr_i  in  32  branch/jump target
- load_use_i  in  1  ID source register matches EX load destination
- div_busy_i  in  1  multi-cycle divider busy
- bus_busy_i  in  1  LSU bus transaction outstanding
- trap_req_i  in  1  interrupt/ecall/mret request, level, held until trap_ack_o
- trap_addr_i  in  32  trap vector or mepc
- hold_flag_o  out  3  `Hold_Flag_Bus: 000 none, 001 hold PC, 010 hold PC+IF_ID, 011 hold PC+IF_ID+ID_EX
- pip_flush_o  out  1  kill IF_ID and ID_EX contents
- jump_flag_o  out  1  redirect PC this cycle
- jump_addr_o  out  32  redirect target
- trap_ack_o  out  1  one-cycle trap acceptance pulse
- stall_timeout_o  out  1  sticky bus-stall watchdog flag

Function
REQ-002 SHALL contain trap FSM states IDLE, DRAIN, REDIRECT; encoding free.
REQ-003 In IDLE with trap_req_i=1: bus_busy_i=1 -> DRAIN; bus_busy_i=0 -> REDIRECT; trap_addr_i captured into an internal register on the same edge.
REQ-004 DRAIN SHALL drive hold_flag_o=011 and stay until bus_busy_i=0, then -> REDIRECT.
REQ-005 REDIRECT SHALL last exactly one cycle: jump_flag_o=1, jump_addr_o=captured address, pip_flush_o=1, trap_ack_o=1, hold_flag_o=000; then -> IDLE.
REQ-006 In IDLE, combinational outputs SHALL be resolved by fixed priority: trap_req_i > ex_jump_req_i > bus_busy_i > div_busy_i > load_use_i.
REQ-007 ex_jump_req_i (IDLE, no trap) SHALL give jump_flag_o=1, jump_addr_o=ex_jump_addr_i, pip_flush_o=1 in the same cycle (zero latency).
REQ-008 bus_busy_i or div_busy_i SHALL give hold_flag_o=011 for every cycle asserted.
REQ-009 load_use_i SHALL give hold_flag_o=010 and pip_flush_o=0 for exactly one cycle per hazard; an internal bit SHALL block a second hold on the next cycle while load_use_i is still high, and SHALL clear once load_use_i drops.
REQ-010 Simultaneous ex_jump_req_i and load_use_i: jump wins; the load-use hold is dropped.
REQ-011 trap_req_i arriving on the same cycle as ex_jump_req_i: the jump SHALL NOT redirect; the FSM leaves IDLE.
REQ-012 Unused outputs SHALL be 0; jump_addr_o=0 when jump_flag_o=0.

Reset
REQ-013 rst_n=1 at a rising edge SHALL force state IDLE, clear the captured address, load-use block bit, watchdog counter and stall_timeout_o.
REQ-014 During reset all outputs SHALL be 0, hold_flag_o=000.
REQ-015 Reset asserted in DRAIN or REDIRECT SHALL abort the trap with no trap_ack_o pulse.

Configuration
REQ-016 Macro PIPE_CTRL_STALL_TIMEOUT_EN defined: an 8-bit counter SHALL increment on each consecutive bus_busy_i=1 cycle, clear when bus_busy_i=0, saturate at 255, and set stall_timeout_o=1 on reaching 255, held until reset.
REQ-017 Macro undefined: no counter is built; stall_timeout_o is tied to 0.

Verification
REQ-018 The bench SHALL cover:
- ex_jump_req_i=1, addr 0x8000_0040, no other requests -> same cycle jump_flag_o=1, jump_addr_o=0x8000_0040, pip_flush_o=1
- load_use_i high for 3 cycles -> hold_flag_o=010 in cycle 1 only, 000 in cycles 2-3
- trap_req_i=1 (addr 0x8000_0100) with bus_busy_i=1 for 4 cycles -> hold_flag_o=011 for 4 cycles, then one cycle jump_flag_o=1, jump_addr_o=0x8000_0100, pip_flush_o=1, trap_ack_o=1
- trap_req_i and ex_jump_req_i together, bus idle -> no redirect to the jump target; next cycle redirect to trap_addr_i with trap_ack_o=1
- rst_n=1 in DRAIN -> next cycle IDLE, all outputs 0, no trap_ack_o
- PIPE_CTRL_STALL_TIMEOUT_EN defined, bus_busy_i held 300 cycles -> stall_timeout_o rises after 255 busy cycles and stays 1 after bus_busy_i drops; macro undefined -> stays 0
